// File: rtl/bin_load_ctrl_if.sv
// Clause/state memory bus and solver-engine bus seen by bin_load_ctrl.
// master = controller side, slave = memory/engine side.
interface bin_load_ctrl_if #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
);
    localparam int WIDTH_CADDR  = WIDTH_BIN_ID + $clog2(NUM_CLAUSES);
    localparam int WIDTH_CLAUSE = NUM_VARS * 2;
    localparam int WIDTH_VS     = WIDTH_VAR_STATES * NUM_VARS;
    localparam int WIDTH_LS     = WIDTH_LVL_STATES * NUM_LVLS;

    // clause and state memories
    logic                    c_rd_o;
    logic                    c_wr_o;
    logic [WIDTH_CADDR-1:0]  c_addr_o;
    logic [WIDTH_CLAUSE-1:0] c_rdata_i;
    logic [WIDTH_CLAUSE-1:0] c_wdata_o;
    logic                    s_rd_o;
    logic                    s_wr_o;
    logic [WIDTH_BIN_ID-1:0] s_addr_o;
    logic [WIDTH_VS-1:0]     vs_rdata_i;
    logic [WIDTH_VS-1:0]     vs_wdata_o;
    logic [WIDTH_LS-1:0]     ls_rdata_i;
    logic [WIDTH_LS-1:0]     ls_wdata_o;

    // solver engine
    logic                    start_core_o;
    logic [WIDTH_LVL-1:0]    load_lvl_o;
    logic [NUM_CLAUSES-1:0]  wr_carray_o;
    logic [NUM_CLAUSES-1:0]  rd_carray_o;
    logic [WIDTH_CLAUSE-1:0] clause_o;
    logic [NUM_VARS-1:0]     wr_var_states_o;
    logic [WIDTH_VS-1:0]     vars_states_o;
    logic [NUM_LVLS-1:0]     wr_lvl_states_o;
    logic [WIDTH_LS-1:0]     lvl_states_o;
    logic                    base_lvl_en_o;
    logic [WIDTH_LVL-1:0]    base_lvl_o;
    logic                    done_core_i;
    logic                    sat_i;
    logic                    unsat_i;
    logic [WIDTH_LVL-1:0]    bkt_lvl_i;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_i;
    logic [WIDTH_CLAUSE-1:0] clause_i;
    logic [WIDTH_VS-1:0]     vars_states_i;
    logic [WIDTH_LS-1:0]     lvl_states_i;

    modport master (
        output c_rd_o, c_wr_o, c_addr_o, c_wdata_o, s_rd_o, s_wr_o, s_addr_o,
               vs_wdata_o, ls_wdata_o, start_core_o, load_lvl_o, wr_carray_o,
               rd_carray_o, clause_o, wr_var_states_o, vars_states_o,
               wr_lvl_states_o, lvl_states_o, base_lvl_en_o, base_lvl_o,
        input  c_rdata_i, vs_rdata_i, ls_rdata_i, done_core_i, sat_i, unsat_i,
               bkt_lvl_i, bkt_bin_i, clause_i, vars_states_i, lvl_states_i
    );

    modport slave (
        input  c_rd_o, c_wr_o, c_addr_o, c_wdata_o, s_rd_o, s_wr_o, s_addr_o,
               vs_wdata_o, ls_wdata_o, start_core_o, load_lvl_o, wr_carray_o,
               rd_carray_o, clause_o, wr_var_states_o, vars_states_o,
               wr_lvl_states_o, lvl_states_o, base_lvl_en_o, base_lvl_o,
        output c_rdata_i, vs_rdata_i, ls_rdata_i, done_core_i, sat_i, unsat_i,
               bkt_lvl_i, bkt_bin_i, clause_i, vars_states_i, lvl_states_i
    );
endinterface

// File: rtl/bin_load_ctrl.sv
// Loads one bin (clauses + var/lvl states) into the solver engine, runs it, writes it back.
// Latency: start_core NUM_CLAUSES+4 after start, done NUM_CLAUSES+3 after done_core; no backpressure.
module bin_load_ctrl #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_BIN_ID-1:0] bin_id_i,
    input  logic [WIDTH_LVL-1:0]    load_lvl_i,
    input  logic [WIDTH_LVL-1:0]    base_lvl_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    sat_o,
    output logic                    unsat_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    bin_load_ctrl_if.master         bus
);
    localparam int CIW = $clog2(NUM_CLAUSES);
    localparam int KW  = $clog2(NUM_CLAUSES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CLAUSES);

    typedef enum logic [3:0] {
        IDLE, LD_C, LD_S1, LD_S2, START, WAIT, UP_C, UP_S, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [KW-1:0]           k, k_m1;
    logic [WIDTH_BIN_ID-1:0] bin_q;
    logic [WIDTH_LVL-1:0]    load_lvl_q, base_lvl_q;
    logic [NUM_VARS*2-1:0]   clause_q;

    assign k_m1 = k - KW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LD_C;
            LD_C:    if (k == K_LAST) state_nxt = LD_S1;
            LD_S1:   state_nxt = LD_S2;
            LD_S2:   state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (bus.done_core_i) state_nxt = UP_C;
            UP_C:    if (k == K_LAST) state_nxt = UP_S;
            UP_S:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // k walks 0..NUM_CLAUSES in the clause phases and is zero on entry to every state
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            bin_q      <= '0;
            load_lvl_q <= '0;
            base_lvl_q <= '0;
            clause_q   <= '0;
            sat_o      <= 1'b0;
            unsat_o    <= 1'b0;
            bkt_lvl_o  <= '0;
            bkt_bin_o  <= '0;
        end else begin
            if (state_nxt != state)
                k <= '0;
            else if (state == LD_C || state == UP_C)
                k <= k + KW'(1);
            if (state == IDLE && start_i) begin
                bin_q      <= bin_id_i;
                load_lvl_q <= load_lvl_i;
                base_lvl_q <= base_lvl_i;
            end
            if (state == WAIT && bus.done_core_i) begin
                sat_o     <= bus.sat_i;
                unsat_o   <= bus.unsat_i;
                bkt_lvl_o <= bus.bkt_lvl_i;
                bkt_bin_o <= bus.bkt_bin_i;
            end
            if (state == UP_C)
                clause_q <= bus.clause_i;
        end
    end

    // Everything is forced quiet while rst is high so an abandoned job never writes memory.
    always_comb begin
        busy_o              = 1'b0;
        done_o              = 1'b0;
        bus.c_rd_o          = 1'b0;
        bus.c_wr_o          = 1'b0;
        bus.c_addr_o        = '0;
        bus.c_wdata_o       = '0;
        bus.s_rd_o          = 1'b0;
        bus.s_wr_o          = 1'b0;
        bus.s_addr_o        = '0;
        bus.vs_wdata_o      = {(WIDTH_VAR_STATES*NUM_VARS){1'b0}};
        bus.ls_wdata_o      = {(WIDTH_LVL_STATES*NUM_LVLS){1'b0}};
        bus.start_core_o    = 1'b0;
        bus.load_lvl_o      = '0;
        bus.wr_carray_o     = '0;
        bus.rd_carray_o     = '0;
        bus.clause_o        = '0;
        bus.wr_var_states_o = '0;
        bus.vars_states_o   = {(WIDTH_VAR_STATES*NUM_VARS){1'b0}};
        bus.wr_lvl_states_o = '0;
        bus.lvl_states_o    = {(WIDTH_LVL_STATES*NUM_LVLS){1'b0}};
        bus.base_lvl_en_o   = 1'b0;
        bus.base_lvl_o      = '0;
        if (!rst) begin
            busy_o         = (state != IDLE);
            bus.load_lvl_o = load_lvl_q;
            bus.base_lvl_o = base_lvl_q;
            case (state)
                LD_C: begin
                    if (k < K_LAST) begin
                        bus.c_rd_o   = 1'b1;
                        bus.c_addr_o = {bin_q, k[CIW-1:0]};
                    end
                    if (k != '0) begin
                        bus.wr_carray_o[k_m1[CIW-1:0]] = 1'b1;
                        bus.clause_o = bus.c_rdata_i;
                    end
                end
                LD_S1: begin
                    bus.s_rd_o   = 1'b1;
                    bus.s_addr_o = bin_q;
                end
                LD_S2: begin
                    bus.wr_var_states_o = {NUM_VARS{1'b1}};
                    bus.wr_lvl_states_o = {NUM_LVLS{1'b1}};
                    bus.vars_states_o   = bus.vs_rdata_i;
                    bus.lvl_states_o    = bus.ls_rdata_i;
                end
                START: begin
                    bus.start_core_o  = 1'b1;
                    bus.base_lvl_en_o = 1'b1;
                end
                UP_C: begin
                    if (k < K_LAST)
                        bus.rd_carray_o[k[CIW-1:0]] = 1'b1;
                    // write lags the engine read by one cycle via clause_q
                    if (k != '0) begin
                        bus.c_wr_o    = 1'b1;
                        bus.c_addr_o  = {bin_q, k_m1[CIW-1:0]};
                        bus.c_wdata_o = clause_q;
                    end
                end
                UP_S: begin
                    bus.s_wr_o     = 1'b1;
                    bus.s_addr_o   = bin_q;
                    bus.vs_wdata_o = bus.vars_states_i;
                    bus.ls_wdata_o = bus.lvl_states_i;
                end
                DONE:    done_o = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_load_ctrl.sv
// Bench for bin_load_ctrl: memory/engine models plus a cycle-schedule reference derived from job timing.
module tb_bin_load_ctrl;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [9:0]  bin_id_i;
    logic [15:0] load_lvl_i, base_lvl_i;
    logic        busy_o, done_o, sat_o, unsat_o;
    logic [15:0] bkt_lvl_o;
    logic [9:0]  bkt_bin_o;

    bin_load_ctrl_if bus ();

    bin_load_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bin_id_i(bin_id_i),
        .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i), .busy_o(busy_o),
        .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .bkt_lvl_o(bkt_lvl_o),
        .bkt_bin_o(bkt_bin_o), .bus(bus)
    );

    always #5 clk = ~clk;

    // memories as seen by the DUT, and the contents the bench expects them to hold
    logic [15:0]  cmem [8192];
    logic [15:0]  ref_c [8192];
    logic [151:0] vsmem [1024];
    logic [151:0] ref_vs [1024];
    logic [87:0]  lsmem [1024];
    logic [87:0]  ref_ls [1024];

    // engine model
    logic [15:0]  eng_c [N];
    logic [151:0] eng_vs;
    logic [87:0]  eng_ls;

    always_comb begin
        bus.clause_i = '0;
        for (int i = 0; i < N; i++)
            if (bus.rd_carray_o[i]) bus.clause_i = eng_c[i];
    end
    assign bus.vars_states_i = eng_vs;
    assign bus.lvl_states_i  = eng_ls;

    // expectations for the current cycle
    logic         e_busy, e_done, e_c_rd, e_c_wr, e_s_rd, e_s_wr, e_start, e_wrs;
    logic [7:0]   e_wrc, e_rdc;
    logic [12:0]  e_caddr;
    logic [9:0]   e_saddr;
    logic [15:0]  e_data, e_ll, e_bl;
    logic [151:0] e_vs;
    logic [87:0]  e_ls;
    logic [27:0]  e_res;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clr_exp();
        e_busy = 1'b1; e_done = 1'b0; e_c_rd = 1'b0; e_c_wr = 1'b0;
        e_s_rd = 1'b0; e_s_wr = 1'b0; e_start = 1'b0; e_wrs = 1'b0;
        e_wrc = '0; e_rdc = '0; e_caddr = '0; e_saddr = '0;
        e_data = '0; e_ll = '0; e_bl = '0; e_vs = '0; e_ls = '0;
    endtask

    // Check one cycle at the falling edge, then play the memories across the rising edge.
    task automatic cycle_chk();
        logic         rd_c, wr_c, rd_s, wr_s;
        logic [12:0]  ca;
        logic [15:0]  cw;
        logic [9:0]   sa;
        logic [151:0] vw;
        logic [87:0]  lw;
        @(negedge clk);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
        chk("c_rd", bus.c_rd_o, e_c_rd);
        chk("c_wr", bus.c_wr_o, e_c_wr);
        chk("s_rd", bus.s_rd_o, e_s_rd);
        chk("s_wr", bus.s_wr_o, e_s_wr);
        chk("start_core", bus.start_core_o, e_start);
        chk("base_lvl_en", bus.base_lvl_en_o, e_start);
        chk("wr_carray", bus.wr_carray_o, e_wrc);
        chk("rd_carray", bus.rd_carray_o, e_rdc);
        chk("wr_var_states", bus.wr_var_states_o, e_wrs ? 8'hff : 8'h00);
        chk("wr_lvl_states", bus.wr_lvl_states_o, e_wrs ? 8'hff : 8'h00);
        chk("result", {sat_o, unsat_o, bkt_lvl_o, bkt_bin_o}, e_res);
        if (e_c_rd || e_c_wr) chk("c_addr", bus.c_addr_o, e_caddr);
        if (e_wrc != '0) chk("clause_o", bus.clause_o, e_data);
        if (e_c_wr) chk("c_wdata", bus.c_wdata_o, e_data);
        if (e_s_rd || e_s_wr) chk("s_addr", bus.s_addr_o, e_saddr);
        if (e_wrs) begin
            chk("vars_states_o", bus.vars_states_o, e_vs);
            chk("lvl_states_o", bus.lvl_states_o, e_ls);
        end
        if (e_s_wr) begin
            chk("vs_wdata", bus.vs_wdata_o, e_vs);
            chk("ls_wdata", bus.ls_wdata_o, e_ls);
        end
        if (e_start) begin
            chk("load_lvl_o", bus.load_lvl_o, e_ll);
            chk("base_lvl_o", bus.base_lvl_o, e_bl);
        end
        rd_c = bus.c_rd_o; wr_c = bus.c_wr_o; ca = bus.c_addr_o; cw = bus.c_wdata_o;
        rd_s = bus.s_rd_o; wr_s = bus.s_wr_o; sa = bus.s_addr_o;
        vw = bus.vs_wdata_o; lw = bus.ls_wdata_o;
        @(posedge clk);
        #1;
        if (rd_c) bus.c_rdata_i = cmem[ca];
        if (wr_c) cmem[ca] = cw;
        if (rd_s) begin bus.vs_rdata_i = vsmem[sa]; bus.ls_rdata_i = lsmem[sa]; end
        if (wr_s) begin vsmem[sa] = vw; lsmem[sa] = lw; end
    endtask

    task automatic idle_cycle(input bit spur);
        clr_exp();
        e_busy = 1'b0;
        if (spur) begin
            bus.done_core_i = 1'b1;
            {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = 28'($urandom);
        end
        cycle_chk();
        bus.done_core_i = 1'b0;
    endtask

    // One job; start is cycle 0, abort_t>0 asserts rst in that load cycle.
    task automatic run_job(input logic [9:0] bin, input int wcyc, input logic [27:0] res,
                           input bit poke, input bit spur, input int abort_t);
        logic [15:0] ll, bl;
        ll = 16'($urandom);
        bl = 16'($urandom);
        for (int i = 0; i < N; i++) eng_c[i] = 16'($urandom);
        eng_vs = 152'(rnd());
        eng_ls = 88'(rnd());
        {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = ~res;

        clr_exp();
        e_busy = 1'b0;
        start_i = 1'b1; bin_id_i = bin; load_lvl_i = ll; base_lvl_i = bl;
        cycle_chk();
        start_i = 1'b0; bin_id_i = 10'($urandom);
        load_lvl_i = 16'($urandom); base_lvl_i = 16'($urandom);

        for (int t = 1; t <= N + 4; t++) begin
            clr_exp();
            if (t == abort_t) begin
                rst = 1'b1;
                e_busy = 1'b0;
                cycle_chk();
                rst = 1'b0;
                e_res = '0;
                return;
            end
            if (spur && t == 3) begin
                bus.done_core_i = 1'b1;
                {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = 28'($urandom);
            end
            if (t <= N) begin e_c_rd = 1'b1; e_caddr = {bin, 3'(t - 1)}; end
            if (t >= 2 && t <= N + 1) begin
                e_wrc[t-2] = 1'b1;
                e_data = ref_c[{bin, 3'(t - 2)}];
            end
            if (t == N + 2) begin e_s_rd = 1'b1; e_saddr = bin; end
            if (t == N + 3) begin e_wrs = 1'b1; e_vs = ref_vs[bin]; e_ls = ref_ls[bin]; end
            if (t == N + 4) begin e_start = 1'b1; e_ll = ll; e_bl = bl; end
            cycle_chk();
            bus.done_core_i = 1'b0;
            {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = ~res;
        end

        for (int w = 0; w < wcyc; w++) begin
            clr_exp();
            if (poke && w == wcyc / 2) begin start_i = 1'b1; bin_id_i = ~bin; end
            cycle_chk();
            start_i = 1'b0;
        end

        clr_exp();
        bus.done_core_i = 1'b1;
        {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = res;
        cycle_chk();
        bus.done_core_i = 1'b0;
        {bus.sat_i, bus.unsat_i, bus.bkt_lvl_i, bus.bkt_bin_i} = ~res;
        e_res = res;

        for (int u = 1; u <= N + 3; u++) begin
            clr_exp();
            if (u <= N) e_rdc[u-1] = 1'b1;
            if (u >= 2 && u <= N + 1) begin
                e_c_wr = 1'b1;
                e_caddr = {bin, 3'(u - 2)};
                e_data = eng_c[u-2];
            end
            if (u == N + 2) begin e_s_wr = 1'b1; e_saddr = bin; e_vs = eng_vs; e_ls = eng_ls; end
            if (u == N + 3) e_done = 1'b1;
            cycle_chk();
        end
        for (int i = 0; i < N; i++) ref_c[{bin, 3'(i)}] = eng_c[i];
        ref_vs[bin] = eng_vs;
        ref_ls[bin] = eng_ls;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; bin_id_i = '0; load_lvl_i = '0; base_lvl_i = '0;
        bus.done_core_i = 1'b0; bus.sat_i = 1'b0; bus.unsat_i = 1'b0;
        bus.bkt_lvl_i = '0; bus.bkt_bin_i = '0;
        bus.c_rdata_i = '0; bus.vs_rdata_i = '0; bus.ls_rdata_i = '0;
        for (int i = 0; i < N; i++) eng_c[i] = '0;
        eng_vs = '0; eng_ls = '0;
        for (int i = 0; i < 8192; i++) begin cmem[i] = 16'($urandom); ref_c[i] = cmem[i]; end
        for (int i = 0; i < 1024; i++) begin
            vsmem[i] = 152'(rnd()); ref_vs[i] = vsmem[i];
            lsmem[i] = 88'(rnd());  ref_ls[i] = lsmem[i];
        end

        @(posedge clk);
        #1;
        clr_exp();
        e_busy = 1'b0;
        e_res = '0;
        cycle_chk();
        rst = 1'b0;
        idle_cycle(1'b0);

        // load/writeback timing with a sat result, done_core at cycle 40
        run_job(10'd5, 27, {1'b1, 1'b0, 16'h1234, 10'h0ab}, 1'b0, 1'b0, 0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // unsat capture, start ignored during WAIT, spurious done in LD_C
        run_job(10'd9, 5, {1'b0, 1'b1, 16'd3, 10'd2}, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);

        // reset at k=4 of LD_C, then a full job on the same bin
        run_job(10'd5, 3, 28'h0, 1'b0, 1'b0, 5);
        idle_cycle(1'b0);
        run_job(10'd5, 4, {1'b1, 1'b0, 16'h00ff, 10'h3ff}, 1'b0, 1'b0, 0);

        for (int j = 0; j < 6; j++) begin
            run_job(10'($urandom_range(0, 3)), $urandom_range(0, 10), 28'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bin_load_ctrl.md
BIN_LOAD_CTRL -- requirements
Module: bin_load_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_CLAUSES, 8, clause slots per bin.
- NUM_VARS, 8, variables per bin.
- NUM_LVLS, 8, level slots per bin.
- WIDTH_BIN_ID, 10, bin id width.
- WIDTH_LVL, 16, level width.
- WIDTH_VAR_STATES, 19, per-var state width.
- WIDTH_LVL_STATES, 11, per-level state width.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start_i, in, 1, begin a bin job.
- bin_id_i, in, WIDTH_BIN_ID, bin to process.
- load_lvl_i / base_lvl_i, in, WIDTH_LVL, job parameters.
- busy_o, out, 1, job in progress.
- done_o, out, 1, one-cycle job-complete pulse.
- sat_o / unsat_o, out, 1, latched engine result.
- bkt_lvl_o, out, WIDTH_LVL, latched backtrack level.
- bkt_bin_o, out, WIDTH_BIN_ID, latched backtrack bin.
- c_rd_o / c_wr_o, out, 1, clause memory strobes.
- c_addr_o, out, WIDTH_BIN_ID+log2(NUM_CLAUSES), {bin, clause idx}.
- c_rdata_i, in, NUM_VARS*2, clause read data, 1-cycle latency.
- c_wdata_o, out, NUM_VARS*2, clause write data.
- s_rd_o / s_wr_o, out, 1, state memory strobes, addressed by bin id (s_addr_o, out, WIDTH_BIN_ID).
- vs_rdata_i / vs_wdata_o, in/out, WIDTH_VAR_STATES*NUM_VARS, var-state word.
- ls_rdata_i / ls_wdata_o, in/out, WIDTH_LVL_STATES*NUM_LVLS, lvl-state word.
- Engine side, out: start_core_o, load_lvl_o, wr_carray_o[NUM_CLAUSES], rd_carray_o[NUM_CLAUSES], clause_o, wr_var_states_o[NUM_VARS], vars_states_o, wr_lvl_states_o[NUM_LVLS], lvl_states_o, base_lvl_en_o, base_lvl_o.
- Engine side, in: done_core_i, sat_i, unsat_i, bkt_lvl_i, bkt_bin_i, clause_i, vars_states_i, lvl_states_i.

Function
REQ-004 FSM states SHALL be IDLE, LD_C, LD_S1, LD_S2, START, WAIT, UP_C, UP_S, DONE.

REQ-005 In IDLE, start_i=1 SHALL latch bin_id_i, load_lvl_i and base_lvl_i, clear counter k, and go to LD_C; start_i in any other state SHALL be ignored.

REQ-006 LD_C SHALL last NUM_CLAUSES+1 cycles (k=0..NUM_CLAUSES):
- For k<NUM_CLAUSES: c_rd_o=1, c_addr_o={bin,k}.
- For k>=1: wr_carray_o one-hot bit k-1, clause_o=c_rdata_i.

REQ-007 LD_S1 SHALL assert s_rd_o for one cycle; LD_S2 SHALL assert wr_var_states_o and wr_lvl_states_o all-ones with vars_states_o=vs_rdata_i and lvl_states_o=ls_rdata_i.

REQ-008 START SHALL be a single cycle: start_core_o=1, base_lvl_en_o=1, load_lvl_o/base_lvl_o driving the latched values; then go to WAIT.

REQ-009 WAIT SHALL hold until done_core_i=1, then latch sat_i, unsat_i, bkt_lvl_i, bkt_bin_i and go to UP_C.

REQ-010 UP_C SHALL last NUM_CLAUSES+1 cycles:
- For k<NUM_CLAUSES: rd_carray_o one-hot bit k.
- For k>=1: c_wr_o=1, c_addr_o={bin,k-1}, c_wdata_o=clause_i as registered in the previous cycle.

REQ-011 UP_S SHALL assert s_wr_o for one cycle with vs_wdata_o=vars_states_i and ls_wdata_o=lvl_states_i.

REQ-012 DONE SHALL pulse done_o for one cycle, then return to IDLE.

REQ-013 busy_o SHALL be 1 in every state except IDLE.

REQ-014 The latched result outputs SHALL hold until the next done_core_i capture.

REQ-015 Latency: with start_i accepted at cycle 0, start_core_o SHALL assert at cycle NUM_CLAUSES+4. With done_core_i at cycle d, done_o SHALL assert at cycle d+NUM_CLAUSES+3.

REQ-016 At most one of c_rd_o/c_wr_o and one of s_rd_o/s_wr_o SHALL be high in any cycle; every one-hot vector SHALL be all-zero outside its state.

REQ-017 done_core_i outside WAIT SHALL be ignored; the counter SHALL never exceed NUM_CLAUSES and SHALL clear on every state exit.

Reset
REQ-018 rst=1 SHALL force IDLE in the same edge, from any state including mid-LD_C or WAIT, abandoning the job with no further memory writes.

REQ-019 Reset values SHALL be: all strobes/one-hot vectors 0, done_o=0, busy_o=0, sat_o=0, unsat_o=0, bkt_lvl_o=0, bkt_bin_o=0, all data outputs 0.

Verification
REQ-020 Bench SHALL cover:
- Load latency: N=8, start_i at cycle 0 with bin_id_i=5 -> c_addr_o {5,0..7} on cycles 1..8, wr_carray_o 0x01..0x80 on cycles 2..9, start_core_o at cycle 12.
- Writeback: done_core_i at cycle 40 with sat_i=1 -> c_wr_o on cycles 42..49 with clause_i data, s_wr_o at 50, done_o at 51, sat_o=1.
- Unsat capture: unsat_i=1, bkt_lvl_i=3, bkt_bin_i=2 at done_core_i -> outputs hold 1/3/2 after done_o until the next job.
- Ignored start: start_i pulsed during WAIT -> no state change, no extra memory strobes.
- Reset mid-LD_C (k=4) -> next cycle IDLE, busy_o=0, all strobes 0; a fresh start_i then runs a complete job normally.
- Spurious done: done_core_i=1 while IDLE or in LD_C -> ignored, result outputs unchanged.
